// File: rtl/ysyx_22051468_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_22051468_scoreboard
// Register-dependency scoreboard for the NPC pipeline. Each architectural
// register r (r >= 1) has a small counter holding how many in-flight writes
// target it. Issue is stalled on a RAW hazard against a busy source register,
// on a destination whose counter is saturated, and during a flush.
//
// Optional feature (macro YSYX_22051468_SB_PERF_EN):
//   defined     -> stall_cycles counts cycles with issue_valid & !issue_ready
//   not defined -> stall_cycles is tied to zero
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   issue_valid / issue_ready     decode handshake
//   rd/rs1/rs2_need, _addr        operand usage flags and register addresses
//   wb_valid, wb_addr             per-port writeback strobes and addresses
//   flush                         discard all pending writes
//   busy_vec                      bit r set while register r has pending writes
//   sb_err                        sticky underflow (more writebacks than issues)
//   stall_cycles                  stall performance counter
// ---------------------------------------------------------------------------
module ysyx_22051468_scoreboard #(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 2,
    parameter int WB_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       rd_need,
    input  logic                       rs1_need,
    input  logic                       rs2_need,
    input  logic [REG_AW-1:0]          rd_addr,
    input  logic [REG_AW-1:0]          rs1_addr,
    input  logic [REG_AW-1:0]          rs2_addr,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*REG_AW-1:0] wb_addr,
    input  logic                       flush,
    output logic [REG_NUM-1:0]         busy_vec,
    output logic                       sb_err,
    output logic [31:0]                stall_cycles
);

    // Width able to hold the number of ports that may hit one register.
    localparam int DW = $clog2(WB_PORTS + 1);
    // Working width for cnt + inc, wide enough to compare against dec.
    localparam int SW = CNT_W + DW + 1;

    // x0 is never tracked, so storage starts at index 1.
    logic [REG_NUM-1:1][CNT_W-1:0] cnt_q;
    logic [REG_NUM-1:1][CNT_W-1:0] cnt_d;
    logic [REG_NUM-1:1]            under_s;
    logic [REG_NUM-1:0]            busy_s;
    logic                          hazard_s;
    logic                          fire_s;
    logic                          sb_err_q;

    // Busy flags decoded from the registered counters; x0 is never busy.
    always_comb begin
        busy_s    = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            busy_s[r] = (cnt_q[r] != '0);
        end
    end

    // Hazard detection. Matching is done against in-range register indices
    // only, so an address >= REG_NUM (like x0) never matches anything.
    always_comb begin
        hazard_s = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (rs1_need && (rs1_addr == REG_AW'(r)) && busy_s[r]) begin
                hazard_s = 1'b1;
            end else if (rs2_need && (rs2_addr == REG_AW'(r)) && busy_s[r]) begin
                hazard_s = 1'b1;
            end else if (rd_need && (rd_addr == REG_AW'(r)) &&
                         (cnt_q[r] == {CNT_W{1'b1}})) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign issue_ready = !flush && !hazard_s;
    assign fire_s      = issue_valid && issue_ready;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
        logic          inc_s;
        logic [DW-1:0] dec_s;
        logic [SW-1:0] tot_s;

        // Count writeback ports targeting this register in this cycle.
        always_comb begin
            dec_s = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_addr[p*REG_AW +: REG_AW] == REG_AW'(r))) begin
                    dec_s = dec_s + DW'(1);
                end else begin
                    dec_s = dec_s;
                end
            end
        end

        assign inc_s      = fire_s && rd_need && (rd_addr == REG_AW'(r));
        assign tot_s      = SW'(cnt_q[r]) + SW'(inc_s);
        assign under_s[r] = (tot_s < SW'(dec_s));
        // A saturated counter cannot receive inc (issue stalls), so the
        // difference always fits back into CNT_W bits.
        assign cnt_d[r]   = under_s[r] ? '0 : CNT_W'(tot_s - SW'(dec_s));
    end

    // Counter state and sticky error; flush wins over issue, wb and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else if (flush) begin
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            if (|under_s) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_s;
    assign sb_err   = sb_err_q;

`ifdef YSYX_22051468_SB_PERF_EN
    logic [31:0] stall_q;

    // Stall counter, wraps naturally; unaffected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (issue_valid && !issue_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_22051468_scoreboard.sv
module tb_ysyx_22051468_scoreboard;

    localparam int MAXC = 3;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic        rd_need, rs1_need, rs2_need;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_addr;
    logic        flush;
    logic [31:0] busy_vec;
    logic        sb_err;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model: plain pending-write counts per register.
    int          m_cnt [32];
    bit          m_err;
    int unsigned m_stall;

    ysyx_22051468_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .rd_need     (rd_need),
        .rs1_need    (rs1_need),
        .rs2_need    (rs2_need),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .busy_vec    (busy_vec),
        .sb_err      (sb_err),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        bit hz;
        hz = (rs1_need && rs1_addr != 0 && m_cnt[rs1_addr] > 0) ||
             (rs2_need && rs2_addr != 0 && m_cnt[rs2_addr] > 0) ||
             (rd_need  && rd_addr  != 0 && m_cnt[rd_addr] == MAXC);
        return !flush && !hz;
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endfunction

    function automatic void m_update();
        bit rdy;
        int nxt [32];
        rdy = m_ready();
        if (issue_valid && !rdy) m_stall++;
        if (flush) begin
            m_clear();
            return;
        end
        nxt[0] = 0;
        for (int r = 1; r < 32; r++) begin
            int d;
            int c;
            d = 0;
            for (int p = 0; p < 2; p++)
                if (wb_valid[p] && wb_addr[p*5 +: 5] == r) d++;
            c = m_cnt[r] - d;
            if (issue_valid && rdy && rd_need && rd_addr == r) c++;
            if (c < 0) begin
                c = 0;
                m_err = 1'b1;
            end
            nxt[r] = c;
        end
        for (int r = 0; r < 32; r++) m_cnt[r] = nxt[r];
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = 32'd0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef YSYX_22051468_SB_PERF_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle();
        issue_valid = 1'b0;
        rd_need = 1'b0; rs1_need = 1'b0; rs2_need = 1'b0;
        rd_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        wb_valid = 2'b00; wb_addr = 10'd0; flush = 1'b0;
    endtask

    task automatic issue(input bit rdn, input logic [4:0] rd,
                         input bit r1n, input logic [4:0] r1,
                         input bit r2n, input logic [4:0] r2);
        issue_valid = 1'b1;
        rd_need = rdn; rd_addr = rd;
        rs1_need = r1n; rs1_addr = r1;
        rs2_need = r2n; rs2_addr = r2;
    endtask

    task automatic wb(input int port, input logic [4:0] a);
        wb_valid[port] = 1'b1;
        wb_addr[port*5 +: 5] = a;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        m_clear(); m_err = 1'b0; m_stall = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy_vec, 32'd0); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", sb_err); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_raw();
        @(negedge clk); idle(); issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b want 1", issue_ready); end
        clk_edge();
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b want 1", busy_vec[5]); end
        @(negedge clk); idle(); issue(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", issue_ready); end
        clk_edge();
        @(negedge clk); wb(0, 5'd5);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b want 0", issue_ready); end
        clk_edge();
        checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clear: got %b want 0", busy_vec[5]); end
        @(negedge clk); wb_valid = 2'b00;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", issue_ready); end
        clk_edge();
        checks++; if (busy_vec !== m_busy()) begin errors++; $display("FAIL raw_state: got %h want %h", busy_vec, m_busy()); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
            #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_fill_ready: got %b want 1 (i=%0d)", issue_ready, i); end
            clk_edge();
        end
        @(negedge clk);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_stall: got %b want 0", issue_ready); end
        clk_edge();
        @(negedge clk); wb(0, 5'd7);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_wb_same_cycle: got %b want 0", issue_ready); end
        clk_edge();
        @(negedge clk); wb_valid = 2'b00;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_release: got %b want 1", issue_ready); end
        clk_edge();
        @(negedge clk); idle(); wb(0, 5'd7); wb(1, 5'd7);
        clk_edge();
        @(negedge clk); idle(); wb(0, 5'd7);
        clk_edge();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL sat_drained: got %h want 0", busy_vec); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_no_err: got %b want 0", sb_err); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); idle(); issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        @(negedge clk); wb(0, 5'd3);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_cycle_ready: got %b want 1", issue_ready); end
        clk_edge();
        checks++; if (busy_vec[3] !== 1'b1) begin errors++; $display("FAIL same_cycle_net0: got %b want 1", busy_vec[3]); end
        @(negedge clk); idle(); issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        @(negedge clk); idle(); wb(0, 5'd3); wb(1, 5'd3);
        clk_edge();
        checks++; if (busy_vec[3] !== 1'b0) begin errors++; $display("FAIL dual_wb_clear: got %b want 0", busy_vec[3]); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL dual_wb_no_err: got %b want 0", sb_err); end
        @(negedge clk); idle(); wb(0, 5'd0);
        clk_edge();
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL wb_x0_no_err: got %b want 0", sb_err); end
    endtask

    task automatic test_flush();
        @(negedge clk); idle(); issue(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        clk_edge();
        @(negedge clk); idle(); issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        checks++; if (busy_vec !== 32'h0000_0050) begin errors++; $display("FAIL flush_setup: got %h want %h", busy_vec, 32'h0000_0050); end
        @(negedge clk); idle(); issue(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        wb(0, 5'd6); wb(1, 5'd9); flush = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        clk_edge();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL flush_clear: got %h want 0", busy_vec); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL flush_no_err: got %b want 0", sb_err); end
        @(negedge clk); idle(); issue(1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd6);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", issue_ready); end
        clk_edge();
    endtask

    task automatic test_perf();
        @(negedge clk); idle(); issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); idle(); issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
            clk_edge();
        end
        checks++; if (stall_cycles !== exp_stall()) begin errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cycles, exp_stall()); end
        @(negedge clk); idle(); wb(1, 5'd5);
        clk_edge();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL perf_cleanup: got %h want 0", busy_vec); end
    endtask

    task automatic test_underflow();
        @(negedge clk); idle(); wb(0, 5'd9);
        clk_edge();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", sb_err); end
        checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL underflow_cnt0: got %b want 0", busy_vec[9]); end
        @(negedge clk); idle();
        clk_edge();
        clk_edge();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", sb_err); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); idle();
            issue_valid = ($urandom_range(0, 3) != 0);
            rd_need  = $urandom_range(0, 1) != 0;
            rs1_need = $urandom_range(0, 1) != 0;
            rs2_need = $urandom_range(0, 1) != 0;
            rd_addr  = 5'($urandom_range(0, 7));
            rs1_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                logic [4:0] a;
                a = 5'($urandom_range(0, 7));
                if (m_cnt[a] > 0 || $urandom_range(0, 15) == 0) wb(p, a);
            end
            flush = ($urandom_range(0, 31) == 0);
            #1;
            checks++; if (issue_ready !== m_ready()) begin errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", i, issue_ready, m_ready()); end
            clk_edge();
            checks++; if (busy_vec !== m_busy()) begin errors++; $display("FAIL rand_busy: cycle %0d got %h want %h", i, busy_vec, m_busy()); end
            checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rand_err: cycle %0d got %b want %b", i, sb_err, m_err); end
            checks++; if (stall_cycles !== exp_stall()) begin errors++; $display("FAIL rand_stall: cycle %0d got %0d want %0d", i, stall_cycles, exp_stall()); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle(); issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        clk_edge();
        @(negedge clk); idle(); issue(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0);
        #2;
        rst_n = 1'b0;
        m_clear(); m_err = 1'b0; m_stall = 0;
        #1;
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL async_rst_busy: got %h want 0", busy_vec); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b want 0", sb_err); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL async_rst_stall: got %0d want 0", stall_cycles); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b want 1", issue_ready); end
        @(negedge clk); rst_n = 1'b1; idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_saturate();
        test_same_cycle();
        test_flush();
        test_perf();
        test_underflow();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22051468_scoreboard.md
# ysyx_22051468_scoreboard

Register-dependency scoreboard for the NPC pipeline: tracks outstanding writes per architectural register and stalls issue on RAW hazards or counter saturation. Sits between decode, which supplies rd/rs1/rs2 need flags and addresses, and issue. Parametrised in register count, per-register outstanding-write depth and writeback port count. Replaces per-instruction need decoding with stateful hazard tracking.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers tracked (x0 included, never busy)
- REG_AW, 5, register address width; 2^REG_AW >= REG_NUM
- CNT_W, 2, per-register pending counter width; max outstanding writes = 2^CNT_W-1
- WB_PORTS, 2, number of writeback ports

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it
- rd_need / rs1_need / rs2_need  in  1 each  operand-usage flags from decode
- rd_addr / rs1_addr / rs2_addr  in  REG_AW each  register addresses
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_addr  in  WB_PORTS*REG_AW  per-port writeback register; port i at [i*REG_AW +: REG_AW]
- flush  in  1  pipeline flush; discards all pending writes
- busy_vec  out  REG_NUM  bit r = pending count of r nonzero
- sb_err  out  1  sticky underflow error
- stall_cycles  out  32  stall performance counter (see Configuration)

## Operation
- State: cnt[r], CNT_W bits, r = 1..REG_NUM-1; cnt[0] is a constant 0.
- hazard = (rs1_need & busy(rs1_addr)) | (rs2_need & busy(rs2_addr)) | (rd_need & rd_addr!=0 & cnt[rd_addr]==max).
- issue_ready = !flush & !hazard; combinational from registered state and current inputs.
- No writeback bypass: a same-cycle wb does not clear a hazard; it clears next cycle.
- fire = issue_valid & issue_ready.
- Per-register update, r != 0: inc = fire & rd_need & rd_addr==r; dec = number of ports with wb_valid & wb_addr==r; cnt[r] <= cnt[r] + inc - dec.
- Underflow: if cnt[r] + inc < dec, cnt[r] is set to 0 and sb_err is set. sb_err is cleared only by reset.
- wb to x0 is ignored and is not an error.
- Addresses >= REG_NUM behave as x0.
- flush: next-cycle state is all cnt = 0. Flush overrides any same-cycle issue and wb, and sb_err is not updated in that cycle.
- busy_vec[r] = (cnt[r] != 0); bit 0 is always 0.

## Timing
- Reset (async assert on rst_n low): all cnt = 0, busy_vec = 0, sb_err = 0, stall_cycles = 0. issue_ready reads 1 when flush is low.
- Issue-to-busy latency: 1 cycle. busy_vec reflects fire in the cycle after fire.
- Writeback-to-clear latency: 1 cycle. A dependent instruction can fire in the cycle after the last matching wb.
- Simultaneous issue of rd=r and wb to r in one cycle gives a net change of 0. No stall is caused for rd itself unless cnt was already at max.
- Two wb ports hitting the same r in one cycle decrement it by 2.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- Macro: YSYX_22051468_SB_PERF_EN.
- Defined: stall_cycles increments by 1 on every cycle with issue_valid & !issue_ready. It wraps modulo 2^32, is not cleared by flush, and is cleared only by reset.
- Not defined: no counter register; stall_cycles is tied to 0.

## Test plan
- Reset then idle: busy_vec = 0, issue_ready = 1, sb_err = 0, stall_cycles = 0.
- Issue rd=5 with rd_need=1, then issue rs1=5 with rs1_need=1: the second issue sees issue_ready = 0. Apply wb_valid[0]=1 with wb_addr=5: issue_ready = 1 the next cycle, busy_vec[5] = 0.
- CNT_W=2: three issues to rd=7 with no wb give cnt=3. A fourth issue with rd=7 stalls. One wb to 7 releases it the next cycle.
- Issue rd=3 and wb to 3 in the same cycle, starting from cnt[3]=1: cnt[3] stays 1. Separately, wb to 9 with cnt[9]=0 sets sb_err = 1, cnt[9] stays 0, and sb_err stays 1 afterwards.
- With cnt[4]=2, cnt[6]=1 and flush=1: issue_ready = 0 in the flush cycle, then busy_vec = 0 and issue_ready = 1 the next cycle.
- With YSYX_22051468_SB_PERF_EN defined, hold a RAW stall for 10 cycles: stall_cycles = 10. Without the macro, stall_cycles = 0.
